// File: rtl/uart_rx_arbiter_if.sv
// uart_rx_arbiter_if: bundles the per-channel UART receiver strobes, the merged
// output stream and the overrun flags for uart_rx_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// surrounding logic that feeds channels and consumes the merged stream.
// Optional macro UART_ARB_DROP_CNT_EN adds the drop_cnt bus.
interface uart_rx_arbiter_if #(
  parameter int NUM_CH         = 4,
  parameter int WIDTH_DATABITS = 8,
  parameter int WIDTH_ERROR    = 3
) ();
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH_DATABITS-1:0] out;
  logic [NUM_CH-1:0]                valid_out;
  logic [NUM_CH*WIDTH_ERROR-1:0]    error;
  logic [NUM_CH-1:0]                valid_error;
  logic                             m_ready;
  logic                             m_valid;
  logic [WIDTH_DATABITS-1:0]        m_out;
  logic                             m_valid_out;
  logic [WIDTH_ERROR-1:0]           m_error;
  logic                             m_valid_error;
  logic [CH_W-1:0]                  m_ch;
  logic [NUM_CH-1:0]                drop_sticky;
  logic                             drop_clr;
`ifdef UART_ARB_DROP_CNT_EN
  logic [NUM_CH*8-1:0]              drop_cnt;

  modport slave (
    input  out, valid_out, error, valid_error, m_ready, drop_clr,
    output m_valid, m_out, m_valid_out, m_error, m_valid_error, m_ch,
           drop_sticky, drop_cnt
  );
  modport master (
    output out, valid_out, error, valid_error, m_ready, drop_clr,
    input  m_valid, m_out, m_valid_out, m_error, m_valid_error, m_ch,
           drop_sticky, drop_cnt
  );
`else
  modport slave (
    input  out, valid_out, error, valid_error, m_ready, drop_clr,
    output m_valid, m_out, m_valid_out, m_error, m_valid_error, m_ch,
           drop_sticky
  );
  modport master (
    output out, valid_out, error, valid_error, m_ready, drop_clr,
    input  m_valid, m_out, m_valid_out, m_error, m_valid_error, m_ch,
           drop_sticky
  );
`endif
endinterface

// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter: merges NUM_CH UART receiver character/error strobes into a
// single ready/valid stream. Each channel owns a one-entry hold register; a
// round-robin arbiter moves one hold per cycle into a single output register.
// Strobes have no backpressure, so a strobe hitting a full, ungranted hold is
// dropped and flagged in drop_sticky.
// Optional macro UART_ARB_DROP_CNT_EN adds saturating 8-bit per-channel drop
// counters on drop_cnt.
module uart_rx_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int WIDTH_DATABITS = 8,
  parameter int WIDTH_ERROR    = 3
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  // Flattened view of all hold registers for the output mux
  logic [NUM_CH*WIDTH_DATABITS-1:0] w_hold_out;
  logic [NUM_CH*WIDTH_ERROR-1:0]    w_hold_error;
  logic [NUM_CH-1:0]                w_hold_vo;
  logic [NUM_CH-1:0]                w_hold_ve;
  logic [NUM_CH-1:0]                w_hold_full;

  logic                             w_free;
  logic                             w_found;
  logic [CH_W-1:0]                  w_grant_ch;

  logic [CH_W-1:0]                  r_last;
  logic                             r_m_valid;
  logic [WIDTH_DATABITS-1:0]        r_m_out;
  logic                             r_m_valid_out;
  logic [WIDTH_ERROR-1:0]           r_m_error;
  logic                             r_m_valid_error;
  logic [CH_W-1:0]                  r_m_ch;

  // The output register can take a new item when empty or being drained now
  assign w_free = !r_m_valid || bus.m_ready;

  // Round-robin search: first full hold after the last granted channel
  always_comb begin
    w_found    = 1'b0;
    w_grant_ch = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(r_last) + k) % NUM_CH;
      if (!w_found && w_hold_full[idx]) begin
        w_found    = 1'b1;
        w_grant_ch = CH_W'(idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                      w_strobe;
      logic                      w_take;
      logic                      w_drop;
      logic [WIDTH_DATABITS-1:0] r_out;
      logic [WIDTH_ERROR-1:0]    r_error;
      logic                      r_vo;
      logic                      r_ve;
      logic                      r_full;
      logic                      r_sticky;

      assign w_strobe = bus.valid_out[gi] | bus.valid_error[gi];
      assign w_take   = w_free && w_found && (w_grant_ch == CH_W'(gi));
      // A grant in the same cycle frees the slot, so the new strobe is not a drop
      assign w_drop   = w_strobe && r_full && !w_take;

      // Hold register: load on any strobe (fields of idle strobes zeroed),
      // empty on grant; an incoming strobe wins over a same-cycle grant
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out   <= '0;
          r_error <= '0;
          r_vo    <= 1'b0;
          r_ve    <= 1'b0;
          r_full  <= 1'b0;
        end else if (w_strobe) begin
          if (!w_drop) begin
            r_out   <= bus.valid_out[gi]   ? bus.out[gi*WIDTH_DATABITS +: WIDTH_DATABITS] : '0;
            r_error <= bus.valid_error[gi] ? bus.error[gi*WIDTH_ERROR +: WIDTH_ERROR]     : '0;
            r_vo    <= bus.valid_out[gi];
            r_ve    <= bus.valid_error[gi];
            r_full  <= 1'b1;
          end
        end else if (w_take) begin
          r_full <= 1'b0;
        end
      end

      // Overrun flag: set on drop, clear has priority over a same-cycle drop
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sticky <= 1'b0;
        end else if (bus.drop_clr) begin
          r_sticky <= 1'b0;
        end else if (w_drop) begin
          r_sticky <= 1'b1;
        end
      end

`ifdef UART_ARB_DROP_CNT_EN
      logic [7:0] r_cnt;

      // Saturating drop counter, cleared together with the sticky flag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (bus.drop_clr) begin
          r_cnt <= '0;
        end else if (w_drop && (r_cnt != 8'hFF)) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end

      assign bus.drop_cnt[gi*8 +: 8] = r_cnt;
`endif

      assign w_hold_out[gi*WIDTH_DATABITS +: WIDTH_DATABITS] = r_out;
      assign w_hold_error[gi*WIDTH_ERROR +: WIDTH_ERROR]     = r_error;
      assign w_hold_vo[gi]    = r_vo;
      assign w_hold_ve[gi]    = r_ve;
      assign w_hold_full[gi]  = r_full;
      assign bus.drop_sticky[gi] = r_sticky;
    end
  endgenerate

  // Output register: load the granted hold when free, otherwise hold stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last          <= CH_W'(NUM_CH - 1);
      r_m_valid       <= 1'b0;
      r_m_out         <= '0;
      r_m_valid_out   <= 1'b0;
      r_m_error       <= '0;
      r_m_valid_error <= 1'b0;
      r_m_ch          <= '0;
    end else if (w_free) begin
      if (w_found) begin
        r_m_valid       <= 1'b1;
        r_m_out         <= w_hold_out[int'(w_grant_ch)*WIDTH_DATABITS +: WIDTH_DATABITS];
        r_m_valid_out   <= w_hold_vo[w_grant_ch];
        r_m_error       <= w_hold_error[int'(w_grant_ch)*WIDTH_ERROR +: WIDTH_ERROR];
        r_m_valid_error <= w_hold_ve[w_grant_ch];
        r_m_ch          <= w_grant_ch;
        r_last          <= w_grant_ch;
      end else begin
        r_m_valid       <= 1'b0;
        r_m_valid_out   <= 1'b0;
        r_m_valid_error <= 1'b0;
      end
    end
  end

  assign bus.m_valid       = r_m_valid;
  assign bus.m_out         = r_m_out;
  assign bus.m_valid_out   = r_m_valid_out;
  assign bus.m_error       = r_m_error;
  assign bus.m_valid_error = r_m_valid_error;
  assign bus.m_ch          = r_m_ch;

endmodule
